// File: rtl/sp1_enc_arb.sv
// Round-robin priority encoder: grants one active requester as a binary index plus
// one-hot under valid/ready, rotating priority past each transferred winner.
module sp1_enc_arb #(
    parameter int N  = 8,
    parameter int EW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic          vld,
    input  logic          rdy,
    output logic [EW-1:0] e,
    output logic [N-1:0]  d,
    output logic [N-1:0]  ack
);

    logic [EW-1:0]  p;
    logic [EW-1:0]  e_nxt;
    logic [EW-1:0]  start;
    logic [N-1:0]   reqm;
    logic [2*N-1:0] rot2;
    logic [EW-1:0]  off;
    logic [EW:0]    sum;
    logic [EW-1:0]  win;
    logic [N-1:0]   win_oh;
    logic           found;
    logic           xfer;

    assign xfer  = vld && rdy;
    assign ack   = d & {N{xfer}};
    assign e_nxt = (e == EW'(N - 1)) ? '0 : e + 1'b1;

    // While holding, the next grant is searched from e+1 with the current winner masked,
    // so a persistent requester cannot win twice in a row.
    assign start = vld ? e_nxt : p;
    assign reqm  = vld ? (req & ~d) : req;

    // Rotate so the search origin lands at bit 0; first set bit is the offset from start.
    assign rot2 = {reqm, reqm} >> start;

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot2[k]) begin
                found = 1'b1;
                off   = EW'(k);
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (EW + 1)'(N))
            sum = sum - (EW + 1)'(N);
        win    = sum[EW-1:0];
        win_oh = {{(N - 1){1'b0}}, 1'b1} << win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            e   <= '0;
            d   <= '0;
            p   <= '0;
        end else if (!vld || rdy) begin
            if (xfer)
                p <= e_nxt;
            if (en && found) begin
                vld <= 1'b1;
                e   <= win;
                d   <= win_oh;
            end else begin
                vld <= 1'b0;
            end
        end
    end

endmodule
